force_writeback_scheduler: RTL and testbench

Shares the single force-cache write port among NUM_REQ force pipelines, one force write per cycle. Uses a round-robin grant, one registered output stage with valid/ready back-pressure, and a run-control FSM that signals when all forces of an evaluation pass have drained. Sits between the force pipeline outputs and the force cache write side.

---
 rtl/force_wb_pkg.sv | 21 ++
 rtl/rr_priority_pick.sv | 31 +++
 rtl/force_writeback_scheduler.sv | 131 +++++++++++++
 tb/tb_force_writeback_scheduler.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/force_wb_pkg.sv
// Shared types, default widths and slice helpers for the force-cache writeback scheduler.
package force_wb_pkg;

    localparam int DEF_NUM_REQ     = 14;
    localparam int DEF_ADDR_WIDTH  = 9;
    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_SRC_WIDTH   = 4;
    localparam int DEF_COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } wb_state_t;

    // LSB position of element idx inside a packed vector of width-bit elements.
    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first valid requester after last_grant, with wrap.
module rr_priority_pick #(
    parameter int N  = 14,
    parameter int IW = 4
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_valid
);

    logic [IW-1:0] idx;

    always_comb begin
        // NOTE: every output gets a default before the search loop, so no path leaves one unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 1; k <= N; k++) begin
            idx = IW'((int'(last_grant) + k) % N);
            if (!any_valid && valid[idx]) begin
                any_valid  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/force_writeback_scheduler.sv
// Round-robin arbiter feeding the single force-cache write port through one registered
// valid/ready stage, with a run-control FSM that pulses done once a pass has drained.
module force_writeback_scheduler
    import force_wb_pkg::*;
#(
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SRC_WIDTH   = DEF_SRC_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            pipe_done,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*3*DATA_WIDTH-1:0] req_force,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            out_valid,
    output logic [ADDR_WIDTH-1:0]           out_addr,
    output logic [3*DATA_WIDTH-1:0]         out_force,
    output logic [SRC_WIDTH-1:0]            out_src,
    input  logic                            out_ready,
    output logic                            busy,
    output logic                            done,
    output logic [COUNT_WIDTH-1:0]          wb_count
);

    wb_state_t                state;
    logic                     done_seen;
    logic [SRC_WIDTH-1:0]     last_grant;
    logic [NUM_REQ-1:0]       grant;
    logic [SRC_WIDTH-1:0]     grant_idx;
    logic                     any_valid;
    logic                     load_en;
    logic                     transfer;
    logic                     drain;
    logic [ADDR_WIDTH-1:0]    sel_addr;
    logic [3*DATA_WIDTH-1:0]  sel_force;

    rr_priority_pick #(
        .N  (NUM_REQ),
        .IW (SRC_WIDTH)
    ) u_pick (
        .valid      (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx),
        .any_valid  (any_valid)
    );

    assign load_en   = (state == RUN) && (!out_valid || out_ready);
    assign transfer  = load_en && any_valid;
    assign drain     = out_valid && out_ready;
    assign req_ready = load_en ? grant : '0;
    assign busy      = (state != IDLE);

    // One-hot grant, so at most one slice is ever selected.
    always_comb begin
        sel_addr  = '0;
        sel_force = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr  = req_addr[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
                sel_force = req_force[slice_lsb(i, 3*DATA_WIDTH) +: 3*DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
        if (rst) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_force  <= '0;
            out_src    <= '0;
            last_grant <= SRC_WIDTH'(NUM_REQ - 1);
        end else if (transfer) begin
            out_valid  <= 1'b1;
            out_addr   <= sel_addr;
            out_force  <= sel_force;
            out_src    <= grant_idx;
            last_grant <= grant_idx;
        end else if (drain) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            done_seen <= 1'b0;
            wb_count  <= '0;
        end else begin
            if (drain && (wb_count != '1)) begin
                wb_count <= wb_count + COUNT_WIDTH'(1);
            end
            case (state)
                IDLE: begin
                    done_seen <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        wb_count <= '0;
                    end
                end
                RUN: begin
                    if (pipe_done) begin
                        done_seen <= 1'b1;
                    end
                    // Drained: no pipeline has more to send and the output stage is empty or emptying.
                    if (done_seen && (req_valid == '0) && (!out_valid || out_ready)) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state     <= IDLE;
                    done      <= 1'b0;
                    done_seen <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_force_writeback_scheduler.sv
// Scoreboard bench for force_writeback_scheduler: a behavioural model predicts grants,
// accepted writes are queued and compared when the force cache takes them.
module tb_force_writeback_scheduler;
    import force_wb_pkg::*;

    localparam int N  = DEF_NUM_REQ;
    localparam int AW = DEF_ADDR_WIDTH;
    localparam int DW = DEF_DATA_WIDTH;
    localparam int SW = DEF_SRC_WIDTH;
    localparam int CW = DEF_COUNT_WIDTH;

    typedef struct packed {
        logic [SW-1:0]   src;
        logic [AW-1:0]   addr;
        logic [3*DW-1:0] frc;
    } wr_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic              pipe_done;
    logic [N-1:0]      req_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*3*DW-1:0] req_force;
    logic [N-1:0]      req_ready;
    logic              out_valid;
    logic [AW-1:0]     out_addr;
    logic [3*DW-1:0]   out_force;
    logic [SW-1:0]     out_src;
    logic              out_ready;
    logic              busy;
    logic              done;
    logic [CW-1:0]     wb_count;

    force_writeback_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pipe_done (pipe_done),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_force (req_force),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_force (out_force),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .wb_count  (wb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    wr_t  sb[$];
    int   src_log[$];
    int   exp_log[$];
    int   drain_cycs[$];

    int              pend[N];
    logic [AW-1:0]   cur_addr[N];
    logic [3*DW-1:0] cur_frc[N];

    wb_state_t       m_state;
    bit              m_ov;
    int              m_last;
    logic [CW-1:0]   m_count;
    bit              m_ds;

    int cyc = 0;
    int last_drain_cyc = -1;
    int done_cyc = -1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_len"}, 128'(src_log.size()), 128'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < src_log.size(); i++)
            check($sformatf("%s[%0d]", tag, i), 128'(src_log[i]), 128'(exp_log[i]));
    endtask

    task automatic new_item(input int i);
        cur_addr[i] = AW'($urandom);
        cur_frc[i]  = {$urandom, $urandom, $urandom};
    endtask

    task automatic model_reset();
        m_state = IDLE;
        m_ov    = 1'b0;
        m_last  = N - 1;
        m_count = '0;
        m_ds    = 1'b0;
        sb.delete();
    endtask

    // One clock: drive requesters, check outputs against the model, advance model on the edge.
    task automatic cycle();
        logic [N-1:0] v;
        logic [N-1:0] exp_rdy;
        int  pick;
        int  idx;
        bit  le;
        bit  drn;
        bit  acc;
        bit  ov_old;
        for (int i = 0; i < N; i++) begin
            v[i] = (pend[i] > 0);
            req_addr[i*AW +: AW]      = cur_addr[i];
            req_force[i*3*DW +: 3*DW] = cur_frc[i];
        end
        req_valid = v;
        #1;
        le   = (m_state == RUN) && (!m_ov || out_ready);
        pick = -1;
        for (int k = 1; k <= N; k++) begin
            idx = (m_last + k) % N;
            if (pick < 0 && v[idx]) pick = idx;
        end
        exp_rdy = '0;
        if (le && pick >= 0) exp_rdy[pick] = 1'b1;
        check("req_ready", 128'(req_ready), 128'(exp_rdy));
        check("out_valid", 128'(out_valid), 128'(m_ov));
        check("busy", 128'(busy), 128'(m_state != IDLE));
        check("done", 128'(done), 128'(m_state == FINISH));
        check("wb_count", 128'(wb_count), 128'(m_count));
        if (m_ov) begin
            if (sb.size() == 0) begin
                check("sb_empty", 128'(1), 128'(0));
            end else begin
                check("out_src", 128'(out_src), 128'(sb[0].src));
                check("out_addr", 128'(out_addr), 128'(sb[0].addr));
                check("out_force", 128'(out_force), 128'(sb[0].frc));
            end
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        drn    = m_ov && out_ready;
        acc    = le && (pick >= 0);
        ov_old = m_ov;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (drn && sb.size() > 0) begin
                src_log.push_back(int'(sb[0].src));
                drain_cycs.push_back(cyc);
                last_drain_cyc = cyc;
                void'(sb.pop_front());
                if (m_count != '1) m_count = m_count + 1'b1;
            end
            if (acc) begin
                sb.push_back('{src: SW'(pick), addr: cur_addr[pick], frc: cur_frc[pick]});
                m_ov   = 1'b1;
                m_last = pick;
                pend[pick]--;
                new_item(pick);
            end else if (drn) begin
                m_ov = 1'b0;
            end
            case (m_state)
                IDLE: begin
                    m_ds = 1'b0;
                    if (start) begin
                        m_state = RUN;
                        m_count = '0;
                    end
                end
                RUN: begin
                    if (m_ds && v == '0 && (!ov_old || drn)) m_state = FINISH;
                    if (pipe_done) m_ds = 1'b1;
                end
                default: begin
                    m_state = IDLE;
                    m_ds    = 1'b0;
                end
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_until_done(input int budget);
        done_cyc = -1;
        for (int n = 0; n < budget && done_cyc < 0; n++) cycle();
        check("done_timeout", 128'(done_cyc >= 0), 128'(1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pipe_done = 1'b0; out_ready = 1'b0;
        req_valid = '0; req_addr = '0; req_force = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 0;
            new_item(i);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_addr", 128'(out_addr), 128'(0));
        check("rst_out_force", 128'(out_force), 128'(0));
        check("rst_out_src", 128'(out_src), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_count", 128'(wb_count), 128'(0));

        // Three requesters held valid: strict 0,1,2 rotation, one write per cycle.
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < 3; i++) pend[i] = 2;
        out_ready = 1'b1;
        src_log.delete(); drain_cycs.delete();
        repeat (9) cycle();
        exp_log = '{0, 1, 2, 0, 1, 2};
        check_log("t1_order");
        if (drain_cycs.size() == 6)
            check("t1_back_to_back", 128'(drain_cycs[5] - drain_cycs[0]), 128'(5));
        else
            check("t1_drains", 128'(drain_cycs.size()), 128'(6));

        // All valid with a 5-cycle stall after the first load.
        src_log.delete();
        for (int i = 0; i < N; i++) pend[i] = 1;
        cycle();
        out_ready = 1'b0;
        repeat (5) cycle();
        out_ready = 1'b1;
        repeat (18) cycle();
        exp_log.delete();
        for (int i = 0; i < N; i++) exp_log.push_back((3 + i) % N);
        check_log("t2_order");

        // Wrap: after granting 13, requester 0 beats 13.
        src_log.delete();
        pend[13] = 1;
        repeat (3) cycle();
        pend[0] = 1; pend[13] = 1;
        repeat (4) cycle();
        exp_log = '{13, 0, 13};
        check_log("t3_wrap");
        pipe_done = 1'b1; cycle(); pipe_done = 1'b0;
        run_until_done(10);
        cycle();

        // IDLE ignores pipe_done and all requesters.
        for (int i = 0; i < N; i++) pend[i] = 1;
        pipe_done = 1'b1;
        repeat (4) cycle();
        pipe_done = 1'b0;
        #1;
        check("t5_ready", 128'(req_ready), 128'(0));
        check("t5_count", 128'(wb_count), 128'(23));
        check("t5_done", 128'(done), 128'(0));
        for (int i = 0; i < N; i++) pend[i] = 0;

        // Short run of three writes; start re-asserted in RUN is ignored.
        start = 1'b1; cycle();
        for (int i = 4; i < 7; i++) pend[i] = 1;
        pipe_done = 1'b1; cycle(); pipe_done = 1'b0;
        cycle(); start = 1'b0;
        run_until_done(20);
        #1;
        check("t4_count", 128'(wb_count), 128'(3));
        check("t4_done_latency", 128'(done_cyc - last_drain_cyc), 128'(1));
        check("t4_busy_after", 128'(busy), 128'(0));
        check("t4_done_after", 128'(done), 128'(0));

        // Reset mid-run while the output stage is stalled.
        start = 1'b1; cycle(); start = 1'b0;
        for (int i = 0; i < N; i++) pend[i] = 1;
        out_ready = 1'b1; cycle();
        out_ready = 1'b0; cycle(); cycle();
        rst = 1'b1; cycle(); rst = 1'b0;
        #1;
        check("t6_out_valid", 128'(out_valid), 128'(0));
        check("t6_busy", 128'(busy), 128'(0));
        check("t6_count", 128'(wb_count), 128'(0));
        src_log.delete();
        start = 1'b1; cycle(); start = 1'b0;
        out_ready = 1'b1;
        repeat (3) cycle();
        exp_log = '{0, 1};
        check_log("t6_first_grant");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
